bconv_stream: RTL and testbench
===============================

BCONV_STREAM -- requirements
Module: bconv_stream

Interface
REQ-001 The block SHALL be configured by these parameters:
- IN_CH, default 8: input channels, 1 bit each.
- OUT_CH, default 16: output channels.
- IMG_W, default 13: input frame width in pixels.
- IMG_H, default 13: input frame height in pixels.
- K, default 3: kernel size.
- WEIGHTS, default all ones: packed weight vector, OUT_CH*IN_CH*K*K bits, indexed [o][c][ky][kx].
- THRESH, default 36 per channel: packed threshold vector, OUT_CH fields of POP_W bits each.

REQ-002 The block SHALL have these ports:
- clk, in, 1: single clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- valid_in, in, 1: pixel_in is valid in this cycle.
- sof_in, in, 1: the current pixel is the first pixel of a frame; sampled only when valid_in=1.
- pixel_in, in, IN_CH: one bit per input channel.
- pixel_out, out, OUT_CH: one bit per output channel.
- valid_out, out, 1: pixel_out is valid in this cycle.
- eof_out, out, 1: marks the last output of a frame.

Function
REQ-003 Input SHALL arrive in raster order, one pixel per accepted cycle (valid_in=1); there is no backpressure.
REQ-004 Column and row counters SHALL advance only on accepted pixels.
- Column wraps IMG_W-1 -> 0 and the row increments.
- After pixel (IMG_H-1, IMG_W-1) both counters SHALL return to 0.
REQ-005 When valid_in=1 and sof_in=1, the accepted pixel SHALL be treated as (0,0) regardless of the counter state.
REQ-006 Convolution SHALL be valid-only (no padding).
- Output map is (IMG_H-K+1) x (IMG_W-K+1); 11x11 at defaults.
- An output is produced for each accepted pixel with row >= K-1 and col >= K-1.
REQ-007 For each output channel o:
- pop_o SHALL be the popcount of XNOR(window bit, weight bit) over IN_CH*K*K bits.
- pixel_out[o] SHALL be 1 iff pop_o >= THRESH[o], compared unsigned.
REQ-008 POP_W SHALL equal clog2(IN_CH*K*K+1), which is 7 at defaults; the popcount SHALL NOT saturate or overflow.
REQ-009 Latency SHALL be 2 cycles, fixed: a pixel accepted in cycle t that completes a window gives valid_out=1 in cycle t+2.
REQ-010 valid_out SHALL be high for exactly one cycle per output.
- It SHALL be low in cycles whose corresponding input cycle had valid_in=0 or an incomplete window.
REQ-011 pixel_out SHALL hold its last value while valid_out=0.
REQ-012 eof_out SHALL be asserted together with valid_out for the output of window (IMG_H-1, IMG_W-1) only.
REQ-013 Back-to-back frames with no idle cycle SHALL be supported.
- Line-buffer rows from the previous frame SHALL NOT produce outputs, because outputs are gated by the counters.
REQ-014 valid_in gaps of any length SHALL be supported.
- Results SHALL be bit-identical to the same frame streamed without gaps.

Reset
REQ-015 On rst_n=0, the following SHALL clear asynchronously: counters, pipeline valid bits, pixel_out, valid_out and eof_out.
REQ-016 Line-buffer and window contents SHALL NOT require reset; they are don't-care until refilled.
REQ-017 Reset asserted mid-frame SHALL abort the frame.
- After release, the next accepted pixel SHALL be (0,0).
- No output of the aborted frame SHALL appear.

Structure
REQ-018 The package bconv_pkg SHALL hold:
- the clog2 function;
- the default IN_CH, OUT_CH, IMG_W, IMG_H and K constants;
- the POP_W derivation.
REQ-019 The sub-module bconv_window SHALL contain:
- K-1 line buffers of IMG_W*IN_CH bits;
- the KxK*IN_CH window register;
- the counters, producing window and window_valid.
REQ-020 The top level SHALL contain:
- the popcount and compare per output channel;
- the output register stage;
- eof generation.

Verification
REQ-021 Ones test: all-ones input, default weights and THRESH.
- First valid_out SHALL come 30 cycles after the first pixel (pixel index 28 plus 2).
- There SHALL be exactly 121 valid_out pulses, all with pixel_out=16'hFFFF.
- eof_out SHALL come on pulse 121.
REQ-022 Zeros test: all-zero input, default weights. Expect 121 pulses, pixel_out=0, and pop=0 observed internally.
REQ-023 Ramp test: pixel_in = pixel index[7:0], 169 pixels.
- Outputs SHALL match a bit-accurate reference model for all 121 outputs.
- A second frame sent back-to-back SHALL yield another 121 outputs and a second eof_out.
REQ-024 Stall test: the ramp frame with valid_in alternating 1/0.
- The output sequence SHALL equal the ramp test's output sequence.
- valid_out pulses SHALL be separated by idle cycles.
REQ-025 sof test: sof_in asserted on ramp pixel 50.
- The counters SHALL restart there.
- The first valid_out SHALL come 2 cycles after the 29th pixel counted from the sof pixel.
REQ-026 Reset test: rst_n pulled low at pixel 80.
- All outputs SHALL be 0 immediately.
- A fresh frame after release SHALL yield exactly 121 outputs, with the first 30 cycles after its first pixel.

Source files
------------

// File: rtl/bconv_pkg.sv
// bconv_pkg -- shared constants and helpers for the binary convolution stream.
// Holds the integer log2 helper, the default geometry of the block and the
// derivation of the popcount width used by the per-channel accumulators.
package bconv_pkg;

  // Ceiling log2; clog2(1) = 0, clog2(73) = 7.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 32'sd0;
    v      = value - 32'sd1;
    while (v > 32'sd0) begin
      result = result + 32'sd1;
      v      = v >> 32'sd1;
    end
    return result;
  endfunction

  // Width of a counter that must hold 0 .. n-1 (never narrower than one bit).
  function automatic int cnt_width(input int n);
    return (clog2(n) > 32'sd0) ? clog2(n) : 32'sd1;
  endfunction

  // Popcount width: must hold the full count 0 .. IN_CH*K*K without wrapping.
  function automatic int pop_width(input int in_ch, input int k);
    return clog2(in_ch * k * k + 32'sd1);
  endfunction

  localparam int DEF_IN_CH  = 32'sd8;
  localparam int DEF_OUT_CH = 32'sd16;
  localparam int DEF_IMG_W  = 32'sd13;
  localparam int DEF_IMG_H  = 32'sd13;
  localparam int DEF_K      = 32'sd3;
  localparam int DEF_POP_W  = pop_width(DEF_IN_CH, DEF_K);

endpackage

// File: rtl/bconv_window.sv
// bconv_window -- raster-order line buffering and KxK sliding window.
// Tracks the (row, col) position of each accepted pixel, keeps K-1 previous
// rows in line buffers and shifts a KxK window of IN_CH-bit pixels.
// Window bit (c, ky, kx) is flattened at ((c*K + ky)*K + kx); ky = 0 is the
// oldest row and kx = 0 the leftmost column of the window.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_valid, i_sof    pixel accepted / pixel is frame origin (when i_valid)
//   i_pixel           IN_CH-bit input pixel
//   o_window          flattened window, valid one cycle after acceptance
//   o_window_valid    window is complete (row >= K-1 and col >= K-1)
//   o_window_last     window ends at the last pixel of the frame
module bconv_window
  import bconv_pkg::*;
#(
  parameter int IN_CH = DEF_IN_CH,
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int K     = DEF_K
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  input  logic                   i_sof,
  input  logic [IN_CH-1:0]       i_pixel,
  output logic [IN_CH*K*K-1:0]   o_window,
  output logic                   o_window_valid,
  output logic                   o_window_last
);

  localparam int CW = cnt_width(IMG_W);
  localparam int RW = cnt_width(IMG_H);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 32'sd1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 32'sd1);
  localparam logic [CW-1:0] COL_START = CW'(K - 32'sd1);
  localparam logic [RW-1:0] ROW_START = RW'(K - 32'sd1);

  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic [CW-1:0]    w_col;
  logic [RW-1:0]    w_row;
  logic             r_window_valid;
  logic             r_window_last;
  logic [IN_CH-1:0] r_lb  [K-1][IMG_W];
  logic [IN_CH-1:0] r_win [K][K];

  // Position of the offered pixel; a start-of-frame forces it to the origin.
  always_comb begin
    if (i_sof) begin
      w_col = '0;
      w_row = '0;
    end else begin
      w_col = r_col;
      w_row = r_row;
    end
  end

  // Raster counters and the window-complete / frame-last flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col          <= '0;
      r_row          <= '0;
      r_window_valid <= 1'b0;
      r_window_last  <= 1'b0;
    end else if (i_valid) begin
      r_window_valid <= (w_row >= ROW_START) && (w_col >= COL_START);
      r_window_last  <= (w_row == ROW_LAST) && (w_col == COL_LAST);
      if (w_col == COL_LAST) begin
        r_col <= '0;
        if (w_row == ROW_LAST) begin
          r_row <= '0;
        end else begin
          r_row <= w_row + RW'(32'sd1);
        end
      end else begin
        r_col <= w_col + CW'(32'sd1);
        r_row <= w_row;
      end
    end else begin
      r_window_valid <= 1'b0;
      r_window_last  <= 1'b0;
    end
  end

  // Line buffers and window shift; contents are don't-care until refilled,
  // and stale rows from an earlier frame are masked by the counters.
  always_ff @(posedge clk) begin
    if (i_valid) begin
      for (int ky = 0; ky < K; ky++) begin
        for (int kx = 0; kx < K - 1; kx++) begin
          r_win[ky][kx] <= r_win[ky][kx + 1];
        end
      end
      // New rightmost column: current pixel at the bottom, older rows above.
      r_win[K-1][K-1] <= i_pixel;
      for (int j = 0; j < K - 1; j++) begin
        r_win[K-2-j][K-1] <= r_lb[j][w_col];
      end
      // r_lb[j] holds the row j+1 above the current one, per column.
      r_lb[0][w_col] <= i_pixel;
      for (int j = 1; j < K - 1; j++) begin
        r_lb[j][w_col] <= r_lb[j-1][w_col];
      end
    end
  end

  for (genvar gc = 0; gc < IN_CH; gc++) begin : g_c
    for (genvar gy = 0; gy < K; gy++) begin : g_y
      for (genvar gx = 0; gx < K; gx++) begin : g_x
        assign o_window[(gc*K + gy)*K + gx] = r_win[gy][gx][gc];
      end
    end
  end

  assign o_window_valid = r_window_valid;
  assign o_window_last  = r_window_last;

endmodule

// File: rtl/bconv_stream.sv
// bconv_stream -- streaming binary (XNOR-popcount) KxK convolution.
// Pixels arrive in raster order, one per valid_in cycle; every complete
// window produces one OUT_CH-bit output two cycles after its last pixel.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   valid_in     pixel_in valid this cycle
//   sof_in       current pixel is frame origin (sampled with valid_in)
//   pixel_in     IN_CH one-bit channels
//   pixel_out    OUT_CH thresholded channels, held while valid_out = 0
//   valid_out    one-cycle pulse per output pixel
//   eof_out      marks the output of the frame's last window
module bconv_stream
  import bconv_pkg::*;
#(
  parameter int IN_CH  = DEF_IN_CH,
  parameter int OUT_CH = DEF_OUT_CH,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int K      = DEF_K,
  parameter logic [OUT_CH*IN_CH*K*K-1:0] WEIGHTS = '1,
  localparam int POP_W = pop_width(IN_CH, K),
  parameter logic [OUT_CH*POP_W-1:0] THRESH = {OUT_CH{POP_W'(32'sd36)}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              sof_in,
  input  logic [IN_CH-1:0]  pixel_in,
  output logic [OUT_CH-1:0] pixel_out,
  output logic              valid_out,
  output logic              eof_out
);

  localparam int NB = IN_CH * K * K;

  logic [NB-1:0]     w_window;
  logic              w_window_valid;
  logic              w_window_last;
  logic [POP_W-1:0]  w_pop [OUT_CH];
  logic [OUT_CH-1:0] w_bit;
  logic [OUT_CH-1:0] r_pixel_out;
  logic              r_valid_out;
  logic              r_eof_out;

  bconv_window #(
    .IN_CH (IN_CH),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .K     (K)
  ) u_window (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_valid        (valid_in),
    .i_sof          (sof_in),
    .i_pixel        (pixel_in),
    .o_window       (w_window),
    .o_window_valid (w_window_valid),
    .o_window_last  (w_window_last)
  );

  // Per channel: count window bits equal to the weight bits, then threshold.
  for (genvar go = 0; go < OUT_CH; go++) begin : g_ch
    logic [NB-1:0] w_match;
    assign w_match   = ~(w_window ^ WEIGHTS[go*NB +: NB]);
    assign w_pop[go] = POP_W'($countones(w_match));
    assign w_bit[go] = (w_pop[go] >= THRESH[go*POP_W +: POP_W]);
  end

  // Output register stage; pixel_out only loads on a valid window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pixel_out <= '0;
      r_valid_out <= 1'b0;
      r_eof_out   <= 1'b0;
    end else begin
      r_valid_out <= w_window_valid;
      r_eof_out   <= w_window_last;
      if (w_window_valid) begin
        r_pixel_out <= w_bit;
      end else begin
        r_pixel_out <= r_pixel_out;
      end
    end
  end

  assign pixel_out = r_pixel_out;
  assign valid_out = r_valid_out;
  assign eof_out   = r_eof_out;

endmodule

// File: tb/tb_bconv_stream.sv
// tb_bconv_stream -- self-checking bench for bconv_stream.
// Two instances see the same stimulus: one with default weights/thresholds,
// one with a patterned weight vector and varied thresholds. Expected outputs
// come from a frame-level model that evaluates each output window directly
// from the stored image.
module tb_bconv_stream;

  localparam int IN_CH  = 8;
  localparam int OUT_CH = 16;
  localparam int W      = 13;
  localparam int H      = 13;
  localparam int K      = 3;
  localparam int NB     = IN_CH * K * K;
  localparam int POP_W  = 7;
  localparam int NPIX   = W * H;
  localparam logic [OUT_CH*NB-1:0] WB = {18{64'hA5C3_96F0_1E2D_7B48}};
  localparam logic [OUT_CH*POP_W-1:0] TB = {7'd36, 7'd30, 7'd40, 7'd33, 7'd38, 7'd35, 7'd42, 7'd31,
                                           7'd37, 7'd34, 7'd39, 7'd36, 7'd32, 7'd41, 7'd36, 7'd35};

  logic clk = 1'b0;
  logic rst_n;
  logic valid_in;
  logic sof_in;
  logic [IN_CH-1:0] pixel_in;
  logic [OUT_CH-1:0] pa, pb;
  logic va, vb, ea, eb;

  bconv_stream dut_a (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sof_in(sof_in), .pixel_in(pixel_in),
    .pixel_out(pa), .valid_out(va), .eof_out(ea)
  );

  bconv_stream #(.WEIGHTS(WB), .THRESH(TB)) dut_b (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sof_in(sof_in), .pixel_in(pixel_in),
    .pixel_out(pb), .valid_out(vb), .eof_out(eb)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] pa; logic [15:0] pb; logic eof; int cyc; } cap_t;
  typedef struct { logic [15:0] pa; logic [15:0] pb; logic eof; } exp_t;

  cap_t cap_q[$];
  exp_t exp_q[$];
  logic [7:0] frame [NPIX];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int hold_viol = 0;
  int eof_viol = 0;
  int ab_diff = 0;
  logic [15:0] last_a = 16'h0;
  logic [15:0] last_b = 16'h0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: captures pulses and tallies protocol violations.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) begin
        last_a <= 16'h0;
        last_b <= 16'h0;
      end else begin
        if (va) cap_q.push_back(cap_t'{pa, pb, ea, cyc});
        if (va !== vb || ea !== eb) ab_diff <= ab_diff + 1;
        if (ea && !va) eof_viol <= eof_viol + 1;
        if (!va && (pa !== last_a || pb !== last_b)) hold_viol <= hold_viol + 1;
        if (va) begin
          last_a <= pa;
          last_b <= pb;
        end
      end
    end
  end

  // Output of the window whose bottom-right pixel is (r, c) in 'frame'.
  function automatic logic [15:0] model_out(input int r, input int c, input bit use_b);
    logic [15:0] res;
    int pop;
    int th;
    bit pbit;
    bit wbit;
    for (int o = 0; o < OUT_CH; o++) begin
      pop = 0;
      for (int ch = 0; ch < IN_CH; ch++)
        for (int ky = 0; ky < K; ky++)
          for (int kx = 0; kx < K; kx++) begin
            pbit = frame[(r - K + 1 + ky) * W + (c - K + 1 + kx)][ch];
            wbit = use_b ? WB[((o * IN_CH + ch) * K + ky) * K + kx] : 1'b1;
            if (pbit == wbit) pop++;
          end
      th = use_b ? int'(TB[o*POP_W +: POP_W]) : 36;
      res[o] = (pop >= th);
    end
    return res;
  endfunction

  // Append expected outputs for the first n pixels of 'frame'.
  task automatic build_exp(input int n);
    int r;
    int c;
    for (int idx = 0; idx < n; idx++) begin
      r = idx / W;
      c = idx % W;
      if (r >= K - 1 && c >= K - 1)
        exp_q.push_back(exp_t'{model_out(r, c, 1'b0), model_out(r, c, 1'b1), (idx == NPIX - 1)});
    end
  endtask

  task automatic fill_ramp(input int base);
    for (int i = 0; i < NPIX; i++) frame[i] = 8'(base + i);
  endtask

  task automatic send(input logic [7:0] p, input logic s, output int t);
    @(posedge clk);
    #1;
    valid_in = 1'b1;
    sof_in   = s;
    pixel_in = p;
    t = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      sof_in   = 1'($urandom_range(1, 0));
      pixel_in = 8'($urandom);
    end
  endtask

  // gap_mode: 0 = no gaps, 1 = alternate valid/idle, 2 = random 0..3 idles.
  task automatic stream_frame(input int n, input int gap_mode, input logic sof_first, output int t0);
    int t;
    t0 = 0;
    for (int i = 0; i < n; i++) begin
      send(frame[i], (i == 0) && sof_first, t);
      if (i == 0) t0 = t;
      if (gap_mode == 1) idle(1);
      else if (gap_mode == 2) idle($urandom_range(3, 0));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; valid_in = 1'b0; sof_in = 1'b0; pixel_in = 8'h0;
    #2 rst_n = 1'b0;
    #2;
    n_checks++;
    if ({va, ea, pa} !== 18'h0) begin
      n_fail++; $display("FAIL reset_a: got %h expected 0", {va, ea, pa});
    end
    n_checks++;
    if ({vb, eb, pb} !== 18'h0) begin
      n_fail++; $display("FAIL reset_b: got %h expected 0", {vb, eb, pb});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_ones();
    int t0;
    for (int i = 0; i < NPIX; i++) frame[i] = 8'hFF;
    cap_q.delete(); exp_q.delete();
    build_exp(NPIX);
    stream_frame(NPIX, 0, 1'b1, t0);
    idle(4);
    n_checks++;
    if (cap_q.size() != 121) begin
      n_fail++; $display("FAIL ones_count: got %0d expected 121", cap_q.size());
    end
    n_checks++;
    if (cap_q.size() == 0 || cap_q[0].cyc != t0 + 30) begin
      n_fail++; $display("FAIL ones_latency: got %0d expected %0d", (cap_q.size() == 0) ? -1 : cap_q[0].cyc - t0, 30);
    end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (cap_q[i].pa !== 16'hFFFF || cap_q[i].pb !== exp_q[i].pb || cap_q[i].eof !== (i == 120)) begin
        n_fail++;
        $display("FAIL ones_out[%0d]: got a=%h b=%h eof=%b expected a=ffff b=%h eof=%b",
                 i, cap_q[i].pa, cap_q[i].pb, cap_q[i].eof, exp_q[i].pb, (i == 120));
      end
    end
  endtask

  task automatic test_zeros();
    int t0;
    for (int i = 0; i < NPIX; i++) frame[i] = 8'h00;
    cap_q.delete(); exp_q.delete();
    build_exp(NPIX);
    stream_frame(NPIX, 0, 1'b1, t0);
    idle(4);
    n_checks++;
    if (cap_q.size() != 121) begin
      n_fail++; $display("FAIL zeros_count: got %0d expected 121", cap_q.size());
    end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (cap_q[i].pa !== 16'h0000 || cap_q[i].pb !== exp_q[i].pb || cap_q[i].eof !== exp_q[i].eof) begin
        n_fail++;
        $display("FAIL zeros_out[%0d]: got a=%h b=%h eof=%b expected a=0000 b=%h eof=%b",
                 i, cap_q[i].pa, cap_q[i].pb, cap_q[i].eof, exp_q[i].pb, exp_q[i].eof);
      end
    end
  endtask

  task automatic test_ramp();
    int t0;
    int t1;
    fill_ramp(0);
    cap_q.delete(); exp_q.delete();
    build_exp(NPIX);
    build_exp(NPIX);
    stream_frame(NPIX, 0, 1'b0, t0);
    stream_frame(NPIX, 0, 1'b0, t1);
    idle(4);
    n_checks++;
    if (cap_q.size() != 242) begin
      n_fail++; $display("FAIL ramp_count: got %0d expected 242", cap_q.size());
    end
    n_checks++;
    if (cap_q.size() < 122 || cap_q[121].cyc != t1 + 30) begin
      n_fail++; $display("FAIL ramp_frame2_latency: got %0d expected %0d", (cap_q.size() < 122) ? -1 : cap_q[121].cyc - t1, 30);
    end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (cap_q[i].pa !== exp_q[i].pa || cap_q[i].pb !== exp_q[i].pb || cap_q[i].eof !== exp_q[i].eof) begin
        n_fail++;
        $display("FAIL ramp_out[%0d]: got a=%h b=%h eof=%b expected a=%h b=%h eof=%b",
                 i, cap_q[i].pa, cap_q[i].pb, cap_q[i].eof, exp_q[i].pa, exp_q[i].pb, exp_q[i].eof);
      end
    end
  endtask

  task automatic test_stall();
    int t0;
    int min_gap;
    fill_ramp(0);
    cap_q.delete(); exp_q.delete();
    build_exp(NPIX);
    stream_frame(NPIX, 1, 1'b0, t0);
    idle(4);
    n_checks++;
    if (cap_q.size() != 121) begin
      n_fail++; $display("FAIL stall_count: got %0d expected 121", cap_q.size());
    end
    min_gap = 1000;
    for (int i = 1; i < cap_q.size(); i++)
      if (cap_q[i].cyc - cap_q[i-1].cyc < min_gap) min_gap = cap_q[i].cyc - cap_q[i-1].cyc;
    n_checks++;
    if (min_gap < 2) begin
      n_fail++; $display("FAIL stall_gap: got min spacing %0d expected >= 2", min_gap);
    end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (cap_q[i].pa !== exp_q[i].pa || cap_q[i].pb !== exp_q[i].pb || cap_q[i].eof !== exp_q[i].eof) begin
        n_fail++;
        $display("FAIL stall_out[%0d]: got a=%h b=%h eof=%b expected a=%h b=%h eof=%b",
                 i, cap_q[i].pa, cap_q[i].pb, cap_q[i].eof, exp_q[i].pa, exp_q[i].pb, exp_q[i].eof);
      end
    end
  endtask

  task automatic test_sof();
    int t0;
    int t1;
    cap_q.delete(); exp_q.delete();
    fill_ramp(0);
    build_exp(50);
    stream_frame(50, 0, 1'b0, t0);
    fill_ramp(50);
    build_exp(NPIX);
    stream_frame(NPIX, 0, 1'b1, t1);
    idle(4);
    n_checks++;
    if (cap_q.size() != 141) begin
      n_fail++; $display("FAIL sof_count: got %0d expected 141", cap_q.size());
    end
    n_checks++;
    if (cap_q.size() < 21 || cap_q[20].cyc != t1 + 30) begin
      n_fail++; $display("FAIL sof_latency: got %0d expected %0d", (cap_q.size() < 21) ? -1 : cap_q[20].cyc - t1, 30);
    end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (cap_q[i].pa !== exp_q[i].pa || cap_q[i].pb !== exp_q[i].pb || cap_q[i].eof !== exp_q[i].eof) begin
        n_fail++;
        $display("FAIL sof_out[%0d]: got a=%h b=%h eof=%b expected a=%h b=%h eof=%b",
                 i, cap_q[i].pa, cap_q[i].pb, cap_q[i].eof, exp_q[i].pa, exp_q[i].pb, exp_q[i].eof);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    int t1;
    int n_before;
    cap_q.delete(); exp_q.delete();
    fill_ramp(0);
    stream_frame(80, 0, 1'b0, t0);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({va, ea, pa, vb, eb, pb} !== 36'h0) begin
      n_fail++; $display("FAIL midreset_outputs: got %h expected 0", {va, ea, pa, vb, eb, pb});
    end
    n_before = cap_q.size();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(4);
    n_checks++;
    if (cap_q.size() != n_before) begin
      n_fail++; $display("FAIL midreset_aborted: got %0d outputs after reset expected 0", cap_q.size() - n_before);
    end
    cap_q.delete(); exp_q.delete();
    build_exp(NPIX);
    stream_frame(NPIX, 0, 1'b0, t1);
    idle(4);
    n_checks++;
    if (cap_q.size() != 121) begin
      n_fail++; $display("FAIL midreset_count: got %0d expected 121", cap_q.size());
    end
    n_checks++;
    if (cap_q.size() == 0 || cap_q[0].cyc != t1 + 30) begin
      n_fail++; $display("FAIL midreset_latency: got %0d expected %0d", (cap_q.size() == 0) ? -1 : cap_q[0].cyc - t1, 30);
    end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (cap_q[i].pa !== exp_q[i].pa || cap_q[i].pb !== exp_q[i].pb || cap_q[i].eof !== exp_q[i].eof) begin
        n_fail++;
        $display("FAIL midreset_out[%0d]: got a=%h b=%h eof=%b expected a=%h b=%h eof=%b",
                 i, cap_q[i].pa, cap_q[i].pb, cap_q[i].eof, exp_q[i].pa, exp_q[i].pb, exp_q[i].eof);
      end
    end
  endtask

  task automatic test_random();
    int t0;
    cap_q.delete(); exp_q.delete();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NPIX; i++) frame[i] = 8'($urandom);
      build_exp(NPIX);
      stream_frame(NPIX, 2, 1'b1, t0);
    end
    idle(6);
    n_checks++;
    if (cap_q.size() != 242) begin
      n_fail++; $display("FAIL random_count: got %0d expected 242", cap_q.size());
    end
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (cap_q[i].pa !== exp_q[i].pa || cap_q[i].pb !== exp_q[i].pb || cap_q[i].eof !== exp_q[i].eof) begin
        n_fail++;
        $display("FAIL random_out[%0d]: got a=%h b=%h eof=%b expected a=%h b=%h eof=%b",
                 i, cap_q[i].pa, cap_q[i].pb, cap_q[i].eof, exp_q[i].pa, exp_q[i].pb, exp_q[i].eof);
      end
    end
  endtask

  task automatic test_protocol();
    n_checks++;
    if (hold_viol != 0) begin
      n_fail++; $display("FAIL pixel_hold: got %0d changes while idle expected 0", hold_viol);
    end
    n_checks++;
    if (eof_viol != 0) begin
      n_fail++; $display("FAIL eof_without_valid: got %0d expected 0", eof_viol);
    end
    n_checks++;
    if (ab_diff != 0) begin
      n_fail++; $display("FAIL instance_timing: got %0d differing cycles expected 0", ab_diff);
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_zeros();
    test_ramp();
    test_stall();
    test_sof();
    test_reset_mid();
    test_random();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
